// File: rtl/dom_and_sched_pkg.sv
// dom_pkg: FSM encoding, gadget latency and share helper shared by the scheduler and its bench
package dom_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CAPT, RESP} state_e;
  localparam int GADGET_LAT = 1;
  function automatic logic [63:0] share_unmask(input logic [63:0] a, input logic [63:0] b);
    return a ^ b;
  endfunction
endpackage

// File: rtl/dom_and_sched_gadget.sv
// dom_and_gadget: 1-bit 2-share DOM AND; cross terms are re-masked with z and registered
module dom_and_gadget (
  input  logic clk,
  input  logic rst_n,
  input  logic ax,
  input  logic ay,
  input  logic bx,
  input  logic by,
  input  logic z,
  output logic aq,
  output logic bq
);
  logic ca_q, cb_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ca_q <= 1'b0;
      cb_q <= 1'b0;
    end else begin
      ca_q <= (ax & by) ^ z;
      cb_q <= (bx & ay) ^ z;
    end
  end
  assign aq = (ax & ay) ^ ca_q;
  assign bq = (bx & by) ^ cb_q;
endmodule

// File: rtl/dom_and_sched_rr_arb.sv
// rr_arb: N-way round-robin arbiter, combinational grant, pointer advances past the winner on en
module rr_arb #(
  parameter int N = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);
  logic [IDW-1:0] ptr_q, ptr_d;
  int idx;
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    any = 1'b0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        gnt_id = IDW'(idx);
        any = 1'b1;
      end
    end
    ptr_d = en ? ((gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/dom_and_sched.sv
// dom_and_sched: round-robin sequencer feeding held operand shares and one fresh random word
// per operation through a W-bit array of DOM AND gadgets, returning the masked product
module dom_and_sched import dom_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_ax,
  input  logic [N*W-1:0] req_ay,
  input  logic [N*W-1:0] req_bx,
  input  logic [N*W-1:0] req_by,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  input  logic [W-1:0]   rnd_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_aq,
  output logic [W-1:0]   res_bq,
  output logic [IDW-1:0] res_id,
  output logic           busy
);
  state_e state_q, state_d;
  logic [W-1:0] ax_q, ay_q, bx_q, by_q, z_q, ax_d, ay_d, bx_d, by_d, z_d;
  logic [W-1:0] aq_q, bq_q, aq_d, bq_d, g_aq, g_bq;
  logic [IDW-1:0] id_q, id_d, rid_q, rid_d, win;
  logic vld_q, vld_d;
  logic [N-1:0] gnt;
  logic any, grant;
  assign grant = (state_q == IDLE) && rnd_valid && any;
  rr_arb #(.N(N), .IDW(IDW)) u_arb (
    .clk(clk), .rst(rst), .en(grant), .req(req_valid),
    .gnt(gnt), .gnt_id(win), .any(any)
  );
  assign req_ready = grant ? gnt : '0;
  assign rnd_ready = grant;
  assign res_valid = vld_q;
  assign res_aq = aq_q;
  assign res_bq = bq_q;
  assign res_id = rid_q;
  assign busy = state_q != IDLE;
  for (genvar i = 0; i < W; i++) begin : g_gad
    dom_and_gadget u_g (
      .clk(clk), .rst_n(~rst),
      .ax(ax_q[i]), .ay(ay_q[i]), .bx(bx_q[i]), .by(by_q[i]), .z(z_q[i]),
      .aq(g_aq[i]), .bq(g_bq[i])
    );
  end
  always_comb begin
    state_d = state_q;
    {ax_d, ay_d, bx_d, by_d, z_d, id_d} = {ax_q, ay_q, bx_q, by_q, z_q, id_q};
    {aq_d, bq_d, rid_d, vld_d} = {aq_q, bq_q, rid_q, vld_q};
    case (state_q)
      IDLE: if (grant) begin
        state_d = LOAD;
        ax_d = req_ax[win*W +: W];
        ay_d = req_ay[win*W +: W];
        bx_d = req_bx[win*W +: W];
        by_d = req_by[win*W +: W];
        z_d = rnd_data;
        id_d = win;
      end
      LOAD: state_d = CAPT;
      CAPT: begin
        state_d = RESP;
        {aq_d, bq_d, rid_d, vld_d} = {g_aq, g_bq, id_q, 1'b1};
        {ax_d, ay_d, bx_d, by_d, z_d, id_d} = '0;
      end
      RESP: if (res_ready) begin
        state_d = IDLE;
        {aq_d, bq_d, rid_d, vld_d} = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {ax_q, ay_q, bx_q, by_q, z_q, id_q} <= '0;
      {aq_q, bq_q, rid_q, vld_q} <= '0;
    end else begin
      state_q <= state_d;
      {ax_q, ay_q, bx_q, by_q, z_q, id_q} <= {ax_d, ay_d, bx_d, by_d, z_d, id_d};
      {aq_q, bq_q, rid_q, vld_q} <= {aq_d, bq_d, rid_d, vld_d};
    end
  end
  a_unmask: assert property (@(posedge clk) disable iff (rst) (state_q == CAPT) |->
    share_unmask(64'(g_aq), 64'(g_bq)) ==
    (share_unmask(64'(ax_q), 64'(bx_q)) & share_unmask(64'(ay_q), 64'(by_q))));
  a_latency: assert property (@(posedge clk) disable iff (rst) rnd_ready |-> ##(GADGET_LAT + 2) res_valid);
endmodule

// File: doc/dom_and_sched.md
Name: dom_and_sched

Overview:
- Sequencing controller for a W-bit array of 2-share DOM AND gadgets.
- Arbitrates round-robin among N requesters that each submit masked operand pairs.
- Consumes exactly one fresh W-bit random word per operation.
- Holds operand shares stable across the gadget's register stage, then returns the masked product with the requester ID over a valid/ready interface.
- Sits between masked-datapath clients (S-box layers, masked adders) and the shared multiplier resource.

Parameters:
- N, 4, number of requesters (≥2).
- W, 8, bit width of each share; W parallel gadgets.
- IDW, $clog2(N), width of the requester ID.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  N  per-requester operation request.
- req_ready  out  N  one-hot accept pulse.
- req_ax, req_ay, req_bx, req_by  in  N*W each  flattened operand shares; requester i uses slice [i*W +: W].
- rnd_valid  in  1  fresh random word available.
- rnd_ready  out  1  random word consumed.
- rnd_data  in  W  random word (Z0 per bit).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_aq, res_bq  out  W each  output shares.
- res_id  out  IDW  requester that issued the result.
- busy  out  1  high in any state other than IDLE.

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; RR pointer=0.
  - All hold, random and result registers cleared to 0.
  - req_ready=0, rnd_ready=0, res_valid=0, res_aq=0, res_bq=0, res_id=0, busy=0.
  - Gadget reset input driven from ~rst.
- States: IDLE -> LOAD -> CAPT -> RESP -> IDLE.
- IDLE:
  - Grants only when some req_valid=1 AND rnd_valid=1.
  - Winner: first asserted requester at or after the RR pointer, modulo N.
  - In that cycle: req_ready[winner]=1 (combinational, one-hot) and rnd_ready=1.
  - On the edge: operand slices latched into hold regs, rnd_data latched into z reg, winner ID saved, pointer <= (winner+1) mod N; go to LOAD.
  - If rnd_valid=0, no req_ready is asserted, whatever req_valid is.
- LOAD: hold regs drive the gadget inputs. The gadget register captures the cross terms XOR z at the end of the cycle. Go to CAPT.
- CAPT:
  - Hold regs are unchanged, so inner products are computed from the same shares.
  - At the edge, gadget Aq/Bq go into res_aq/res_bq and res_valid <= 1.
  - Hold regs and z reg are cleared to 0 on the same edge. Shares are never left resident and randomness is never reused.
  - Go to RESP.
- RESP:
  - res_valid=1 with res_aq/res_bq/res_id stable until res_ready=1.
  - On the handshake edge: res_valid <= 0, result regs cleared, go to IDLE.
  - No new grant in the handshake cycle.
- Latency and throughput:
  - Request accepted at edge t; res_valid is high from t+2.
  - Minimum 4 cycles per operation with res_ready tied high.
- Requesters drop req_valid only after their req_ready. req_ready is never asserted to a non-requesting port.
- Correctness: res_aq^res_bq == (ax^bx)&(ay^by) per bit, for any rnd_data.
- rst asserted mid-operation: the operation is discarded and no result is emitted. Random word and request already consumed stay consumed.
- Random input: one and only one rnd_ready pulse per accepted request. rnd_ready is never asserted in LOAD, CAPT or RESP.

Decomposition:
- Package dom_pkg:
  - state enum typedef (IDLE, LOAD, CAPT, RESP), 2 bits.
  - localparam for gadget latency (1) used to derive the state sequence.
  - Function share_unmask(a,b) for bench and assertions.
- Sub-module rr_arb (N-way round-robin, combinational grant from pointer and request vector, pointer update on an enable).
- W instances of the existing 2-share DOM AND gadget, generated inline.

Test Plan:
- Single requester 1: ax=8'hA5, bx=8'h5A, ay=8'h0F, by=8'hF0, rnd=8'h3C, res_ready=1 -> req_ready[1] pulse at t; res_valid from t+2; res_aq^res_bq=8'hFF&8'hFF=8'hFF; res_id=1.
- All 4 requesters valid, rnd_valid=1 continuously -> grants in order 0,1,2,3,0; each result unmasks correctly; res_id matches.
- rnd_valid=0 for 5 cycles with req_valid[2]=1 -> no req_ready, busy=0; rnd_valid rises -> grant to 2 that cycle.
- res_ready held 0 for 6 cycles in RESP -> res_valid and shares stable; no further req_ready; release -> IDLE the next cycle.
- rst pulsed during CAPT -> next cycle all outputs 0 and state IDLE; no res_valid for that operation; pointer=0.
- 1000 random operations, random rnd_data and stalls -> unmasked product always correct; rnd_ready count equals req_ready count.
